// File: rtl/rc4_decrypt_core_if.sv
// Bundle of the RC4 core's control handshake and its three memory ports.
// master: the RC4 core. slave: the surrounding controller and memories.
interface rc4_decrypt_core_if #(
    parameter int KEY_BYTES = 3
);
    // run control and result
    logic                   start;
    logic [8*KEY_BYTES-1:0] secret_key;
    logic                   busy;
    logic                   done;
    logic                   key_ok;

    // shared 256x8 S-memory port (synchronous read, 1-cycle latency)
    logic [7:0]             s_addr;
    logic [7:0]             s_wdata;
    logic                   s_wren;
    logic [7:0]             s_rdata;

    // encrypted-message ROM (1-cycle latency)
    logic [7:0]             m_addr;
    logic [7:0]             m_rdata;

    // decrypted-message RAM (write only from the core)
    logic [7:0]             d_addr;
    logic [7:0]             d_wdata;
    logic                   d_wren;

    modport master (
        input  start, secret_key, s_rdata, m_rdata,
        output busy, done, key_ok,
        output s_addr, s_wdata, s_wren,
        output m_addr,
        output d_addr, d_wdata, d_wren
    );

    modport slave (
        output start, secret_key, s_rdata, m_rdata,
        input  busy, done, key_ok,
        input  s_addr, s_wdata, s_wren,
        input  m_addr,
        input  d_addr, d_wdata, d_wren
    );
endinterface

// File: rtl/rc4_decrypt_core.sv
// RC4 decryption engine: S-box init, key schedule and keystream generation
// over one shared S-memory port. Each keystream byte is XORed with the
// encrypted ROM and written to the decrypted RAM; an optional printable-text
// check ends the run early so a key-search controller can move on quickly.
module rc4_decrypt_core #(
    parameter int KEY_BYTES   = 3,
    parameter int MSG_LEN     = 32,
    parameter int CHECK_ASCII = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    rc4_decrypt_core_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA_RD_I,    // present i
        ST_KSA_RD_J,    // capture s[i], update j, present j
        ST_KSA_WR_I,    // capture s[j], write s[i] = s[j]
        ST_KSA_WR_J,    // write s[j] = s[i], advance i
        ST_PRGA_RD_I,   // advance i, present i
        ST_PRGA_RD_J,   // capture s[i], update j, present j
        ST_PRGA_WR_I,   // capture s[j], write s[i] = s[j]
        ST_PRGA_WR_J,   // write s[j] = s[i]
        ST_PRGA_RD_K,   // present s[i] + s[j]
        ST_PRGA_OUT,    // write d[k] = keystream ^ ciphertext, check it
        ST_DONE
    } state_t;

    localparam logic [7:0] LAST_K    = 8'(MSG_LEN - 1);
    localparam logic [4:0] LAST_KIDX = 5'(KEY_BYTES - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [7:0]             r_si;
    logic [7:0]             r_sj;
    logic [7:0]             r_k;
    logic [4:0]             r_kidx;     // i mod KEY_BYTES, tracked alongside i
    logic [8*KEY_BYTES-1:0] r_key;
    logic                   r_key_ok;

    logic [7:0]             w_key_byte;
    logic [7:0]             w_j_ksa;
    logic [7:0]             w_j_prga;
    logic [7:0]             w_plain;
    logic                   w_plain_ok;
    logic                   w_abort;
    logic                   w_last;
    logic [7:0]             w_s_addr;
    logic [7:0]             w_s_wdata;
    logic                   w_s_wren;
    logic [7:0]             w_d_wdata;
    logic                   w_d_wren;

    // Key byte 0 sits in the most significant byte of the latched key.
    assign w_key_byte = r_key[8*(KEY_BYTES-1-int'(r_kidx)) +: 8];

    // All index sums wrap modulo 256 through the 8-bit result width.
    assign w_j_ksa  = r_j + bus.s_rdata + w_key_byte;
    assign w_j_prga = r_j + bus.s_rdata;

    // In PRGA_OUT s_rdata holds s[s[i]+s[j]] and m_rdata holds rom[k].
    assign w_plain    = bus.s_rdata ^ bus.m_rdata;
    assign w_plain_ok = ((w_plain >= 8'h61) && (w_plain <= 8'h7A)) || (w_plain == 8'h20);
    assign w_abort    = (CHECK_ASCII != 0) && !w_plain_ok;
    assign w_last     = (r_k == LAST_K);

    // Next-state decode and per-state memory port drive.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_s_addr     = 8'h00;
        w_s_wdata    = 8'h00;
        w_s_wren     = 1'b0;
        w_d_wdata    = 8'h00;
        w_d_wren     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_next = ST_INIT;
            end
            ST_INIT: begin
                w_s_addr  = r_i;
                w_s_wdata = r_i;
                w_s_wren  = 1'b1;
                if (r_i == 8'hFF) w_state_next = ST_KSA_RD_I;
            end
            ST_KSA_RD_I: begin
                w_s_addr     = r_i;
                w_state_next = ST_KSA_RD_J;
            end
            ST_KSA_RD_J: begin
                w_s_addr     = w_j_ksa;
                w_state_next = ST_KSA_WR_I;
            end
            ST_KSA_WR_I: begin
                w_s_addr     = r_i;
                w_s_wdata    = bus.s_rdata;
                w_s_wren     = 1'b1;
                w_state_next = ST_KSA_WR_J;
            end
            ST_KSA_WR_J: begin
                // When i == j this second write lands on the same cell and
                // restores the original s[i], which is the correct swap.
                w_s_addr     = r_j;
                w_s_wdata    = r_si;
                w_s_wren     = 1'b1;
                w_state_next = (r_i == 8'hFF) ? ST_PRGA_RD_I : ST_KSA_RD_I;
            end
            ST_PRGA_RD_I: begin
                w_s_addr     = r_i + 8'd1;
                w_state_next = ST_PRGA_RD_J;
            end
            ST_PRGA_RD_J: begin
                w_s_addr     = w_j_prga;
                w_state_next = ST_PRGA_WR_I;
            end
            ST_PRGA_WR_I: begin
                w_s_addr     = r_i;
                w_s_wdata    = bus.s_rdata;
                w_s_wren     = 1'b1;
                w_state_next = ST_PRGA_WR_J;
            end
            ST_PRGA_WR_J: begin
                w_s_addr     = r_j;
                w_s_wdata    = r_si;
                w_s_wren     = 1'b1;
                w_state_next = ST_PRGA_RD_K;
            end
            ST_PRGA_RD_K: begin
                w_s_addr     = r_si + r_sj;
                w_state_next = ST_PRGA_OUT;
            end
            ST_PRGA_OUT: begin
                // The failing byte is still written before the run ends.
                w_d_wdata = w_plain;
                w_d_wren  = 1'b1;
                if (w_abort || w_last) w_state_next = ST_DONE;
                else                   w_state_next = ST_PRGA_RD_I;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus index, swap and key registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_i      <= 8'h00;
            r_j      <= 8'h00;
            r_si     <= 8'h00;
            r_sj     <= 8'h00;
            r_k      <= 8'h00;
            r_kidx   <= 5'd0;
            r_key    <= '0;
            r_key_ok <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block reading the pre-edge values, independent of order.
            r_state <= w_state_next;

            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_key    <= bus.secret_key;
                        r_key_ok <= 1'b0;
                        r_i      <= 8'h00;
                        r_j      <= 8'h00;
                        r_k      <= 8'h00;
                        r_kidx   <= 5'd0;
                    end
                end
                ST_INIT: begin
                    r_i <= r_i + 8'd1;   // wraps to 0 for the key schedule
                end
                ST_KSA_RD_J: begin
                    r_si <= bus.s_rdata;
                    r_j  <= w_j_ksa;
                end
                ST_KSA_WR_I: begin
                    r_sj <= bus.s_rdata;
                end
                ST_KSA_WR_J: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= (r_kidx == LAST_KIDX) ? 5'd0 : r_kidx + 5'd1;
                    if (r_i == 8'hFF) begin
                        r_j    <= 8'h00;
                        r_kidx <= 5'd0;
                    end
                end
                ST_PRGA_RD_I: begin
                    r_i <= r_i + 8'd1;
                end
                ST_PRGA_RD_J: begin
                    r_si <= bus.s_rdata;
                    r_j  <= w_j_prga;
                end
                ST_PRGA_WR_I: begin
                    r_sj <= bus.s_rdata;
                end
                ST_PRGA_OUT: begin
                    if (w_abort)     r_key_ok <= 1'b0;
                    else if (w_last) r_key_ok <= 1'b1;
                    else             r_k      <= r_k + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.s_addr  = w_s_addr;
    assign bus.s_wdata = w_s_wdata;
    assign bus.s_wren  = w_s_wren;
    assign bus.m_addr  = r_k;
    assign bus.d_addr  = r_k;
    assign bus.d_wdata = w_d_wdata;
    assign bus.d_wren  = w_d_wren;
    assign bus.busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.key_ok  = r_key_ok;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: two instances (plain XOR, and printable-text
// check) with behavioural S-memory, ROM and RAM, compared against a
// software-style RC4 model.
module tb_rc4_decrypt_core;

    localparam int KB    = 3;
    localparam int LEN_A = 9;
    localparam int LEN_B = 11;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    rc4_decrypt_core_if #(.KEY_BYTES(KB)) if_a ();
    rc4_decrypt_core_if #(.KEY_BYTES(KB)) if_b ();

    rc4_decrypt_core #(.KEY_BYTES(KB), .MSG_LEN(LEN_A), .CHECK_ASCII(0)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_a.master)
    );

    rc4_decrypt_core #(.KEY_BYTES(KB), .MSG_LEN(LEN_B), .CHECK_ASCII(1)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_b.master)
    );

    // memory models and activity counters
    logic [7:0] s_mem_a [256];
    logic [7:0] rom_a   [256];
    logic [7:0] d_mem_a [256];
    logic [7:0] s_mem_b [256];
    logic [7:0] rom_b   [256];
    logic [7:0] d_mem_b [256];
    logic       clr_a, clr_b;
    int         swr_a = 0, dwr_a = 0, swr_b = 0, dwr_b = 0;
    int         both_cnt = 0, rstwr_cnt = 0;

    always @(posedge clk) begin
        if (if_a.s_wren) s_mem_a[if_a.s_addr] <= if_a.s_wdata;
        if_a.s_rdata <= s_mem_a[if_a.s_addr];
        if_a.m_rdata <= rom_a[if_a.m_addr];
        if (clr_a) begin
            for (int n = 0; n < 256; n++) d_mem_a[n] <= 8'hEE;
            swr_a <= 0;
            dwr_a <= 0;
        end else begin
            if (if_a.d_wren) d_mem_a[if_a.d_addr] <= if_a.d_wdata;
            if (if_a.s_wren) swr_a <= swr_a + 1;
            if (if_a.d_wren) dwr_a <= dwr_a + 1;
        end
    end

    always @(posedge clk) begin
        if (if_b.s_wren) s_mem_b[if_b.s_addr] <= if_b.s_wdata;
        if_b.s_rdata <= s_mem_b[if_b.s_addr];
        if_b.m_rdata <= rom_b[if_b.m_addr];
        if (clr_b) begin
            for (int n = 0; n < 256; n++) d_mem_b[n] <= 8'hEE;
            swr_b <= 0;
            dwr_b <= 0;
        end else begin
            if (if_b.d_wren) d_mem_b[if_b.d_addr] <= if_b.d_wdata;
            if (if_b.s_wren) swr_b <= swr_b + 1;
            if (if_b.d_wren) dwr_b <= dwr_b + 1;
        end
    end

    always @(posedge clk) begin
        if ((if_a.s_wren && if_a.d_wren) || (if_b.s_wren && if_b.d_wren))
            both_cnt <= both_cnt + 1;
        if (!reset_n && (if_a.s_wren || if_a.d_wren || if_b.s_wren || if_b.d_wren))
            rstwr_cnt <= rstwr_cnt + 1;
    end

    // checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // per-instance accessors
    function automatic logic [7:0] d_at(input int idx, input int a);
        return (idx != 0) ? d_mem_b[8'(a)] : d_mem_a[8'(a)];
    endfunction
    function automatic logic [7:0] s_at(input int idx, input int a);
        return (idx != 0) ? s_mem_b[8'(a)] : s_mem_a[8'(a)];
    endfunction
    function automatic logic [7:0] rom_at(input int idx, input int a);
        return (idx != 0) ? rom_b[8'(a)] : rom_a[8'(a)];
    endfunction
    function automatic logic busy_of(input int idx);
        return (idx != 0) ? if_b.busy : if_a.busy;
    endfunction
    function automatic logic done_of(input int idx);
        return (idx != 0) ? if_b.done : if_a.done;
    endfunction
    function automatic logic keyok_of(input int idx);
        return (idx != 0) ? if_b.key_ok : if_a.key_ok;
    endfunction
    function automatic int dwr_of(input int idx);
        return (idx != 0) ? dwr_b : dwr_a;
    endfunction
    function automatic int swr_of(input int idx);
        return (idx != 0) ? swr_b : swr_a;
    endfunction

    task automatic set_start(input int idx, input logic v);
        if (idx != 0) if_b.start = v;
        else          if_a.start = v;
    endtask
    task automatic set_clr(input int idx, input logic v);
        if (idx != 0) clr_b = v;
        else          clr_a = v;
    endtask
    task automatic set_rom(input int idx, input int a, input logic [7:0] v);
        if (idx != 0) rom_b[8'(a)] = v;
        else          rom_a[8'(a)] = v;
    endtask

    // reference model: textbook RC4, stops after the first rejected byte
    int m_ks [256];
    int m_pt [256];
    int m_s  [256];

    function automatic bit printable(input int p);
        return ((p >= 97) && (p <= 122)) || (p == 32);
    endfunction

    task automatic rc4_ref(input logic [23:0] key, input int len, input bit chk, input int idx,
                           output int nw, output bit ok);
        int s [256];
        int kb [KB];
        int i, j, t, ks, p;
        for (int n = 0; n < KB; n++) kb[n] = int'(key[8*(KB-1-n) +: 8]);
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + kb[n % KB]) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0; j = 0; nw = 0; ok = 1'b1;
        for (int k = 0; k < len; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks = s[(s[i] + s[j]) % 256];
            p  = ks ^ int'(rom_at(idx, k));
            m_ks[k] = ks;
            m_pt[k] = p;
            nw++;
            if (chk && !printable(p)) begin
                ok = 1'b0;
                break;
            end
        end
        for (int n = 0; n < 256; n++) m_s[n] = s[n];
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_addr"}, {8'h00, if_a.s_addr, if_a.m_addr, if_a.d_addr}, 32'h0);
        check({tag, "_data"}, {16'h0, if_a.s_wdata, if_a.d_wdata}, 32'h0);
        check({tag, "_ctrl"}, {27'h0, if_a.s_wren, if_a.d_wren, if_a.busy, if_a.done, if_a.key_ok}, 32'h0);
    endtask

    // One run: start at a negedge, count edges from the accept edge to done.
    task automatic run(input int idx, input logic [23:0] key, input int pulse_at,
                       input int rst_at, input bit init_chk,
                       output int cycles, output bit was_reset);
        bit seen;
        int mis;
        @(negedge clk);
        set_clr(idx, 1'b1);
        @(negedge clk);
        set_clr(idx, 1'b0);
        if (idx != 0) if_b.secret_key = key;
        else          if_a.secret_key = key;
        set_start(idx, 1'b1);
        @(posedge clk);
        #1;
        check("busy_on_accept", busy_of(idx), 1);
        check("key_ok_cleared", keyok_of(idx), 0);
        set_start(idx, 1'b0);
        cycles = 0;
        seen = 1'b0;
        was_reset = 1'b0;
        while (!seen && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (init_chk && cycles == 256) begin
                mis = 0;
                for (int n = 0; n < 256; n++) if (s_at(idx, n) !== 8'(n)) mis++;
                check("init_identity", mis, 0);
                check("init_wren_cycles", swr_of(idx), 256);
            end
            if (cycles == pulse_at)     set_start(idx, 1'b1);
            if (cycles == pulse_at + 1) set_start(idx, 1'b0);
            if (cycles == rst_at) begin
                reset_n = 1'b0;
                #2;
                check_a_zero("rst_mid_run");
                repeat (3) @(posedge clk);
                #1;
                check_a_zero("rst_held");
                @(negedge clk);
                reset_n = 1'b1;
                was_reset = 1'b1;
                return;
            end
            if (done_of(idx)) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("busy_low_at_done", busy_of(idx), 0);
            @(posedge clk);
            #1;
            check("done_one_cycle", done_of(idx), 0);
        end
    endtask

    task automatic verify(input int idx, input logic [23:0] key, input int len,
                          input bit chk, input int cycles);
        int nw, mis;
        bit ok;
        rc4_ref(key, len, chk, idx, nw, ok);
        check("done_latency", cycles, 1280 + 6 * nw);
        check("key_ok", keyok_of(idx), ok);
        check("d_wren_count", dwr_of(idx), nw);
        for (int k = 0; k < nw; k++) check("d_byte", d_at(idx, k), m_pt[k]);
        if (nw < 256) check("d_untouched", d_at(idx, nw), 8'hEE);
        mis = 0;
        for (int n = 0; n < 256; n++) if (s_at(idx, n) !== 8'(m_s[n])) mis++;
        check("s_final", mis, 0);
    endtask

    logic [7:0] known [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    string      pt_str    = "Plaintext";
    string      hw_str    = "hello world";

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc, nw, r;
        bit         rst, ok;
        logic [23:0] key;
        logic [7:0] plain [LEN_B];

        reset_n         = 1'b0;
        if_a.start      = 1'b0;
        if_b.start      = 1'b0;
        if_a.secret_key = '0;
        if_b.secret_key = '0;
        clr_a           = 1'b0;
        clr_b           = 1'b0;
        for (int n = 0; n < 256; n++) begin
            rom_a[n] = 8'($urandom);
            rom_b[n] = 8'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        check_a_zero("reset");
        check("reset_b_ctrl", {if_b.s_wren, if_b.d_wren, if_b.busy, if_b.done, if_b.key_ok}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // init phase snapshot, random ciphertext
        run(0, 24'h000249, 0, 0, 1'b1, cyc, rst);
        verify(0, 24'h000249, LEN_A, 1'b0, cyc);

        // known vector, no text check
        for (int k = 0; k < 9; k++) set_rom(0, k, known[k]);
        run(0, 24'h4B6579, 0, 0, 1'b0, cyc, rst);
        verify(0, 24'h4B6579, LEN_A, 1'b0, cyc);
        check("known_latency", cyc, 1334);
        for (int k = 0; k < 9; k++) check("known_plaintext", d_at(0, k), pt_str[k]);

        // same vector with the text check: 'P' aborts at the first byte
        for (int k = 0; k < 9; k++) set_rom(1, k, known[k]);
        run(1, 24'h4B6579, 0, 0, 1'b0, cyc, rst);
        verify(1, 24'h4B6579, LEN_B, 1'b1, cyc);
        check("abort_byte0", d_at(1, 0), 8'h50);
        check("abort_latency", cyc, 1286);
        check("abort_key_ok", if_b.key_ok, 0);
        check("abort_d_wren_once", dwr_b, 1);

        // start pulse mid-run is ignored
        run(0, 24'h4B6579, 500, 0, 1'b0, cyc, rst);
        verify(0, 24'h4B6579, LEN_A, 1'b0, cyc);
        check("pulse_latency", cyc, 1334);
        for (int k = 0; k < 9; k++) check("pulse_plaintext", d_at(0, k), pt_str[k]);

        // reset during the key schedule, then a clean pass
        run(0, 24'h4B6579, 0, 700, 1'b0, cyc, rst);
        check("reset_taken", rst, 1);
        run(0, 24'h4B6579, 0, 0, 1'b0, cyc, rst);
        verify(0, 24'h4B6579, LEN_A, 1'b0, cyc);
        for (int k = 0; k < 9; k++) check("post_reset_plaintext", d_at(0, k), pt_str[k]);

        // lowercase text passes the check
        rc4_ref(24'h000249, LEN_B, 1'b0, 1, nw, ok);
        for (int k = 0; k < LEN_B; k++) set_rom(1, k, 8'(m_ks[k]) ^ hw_str[k]);
        run(1, 24'h000249, 0, 0, 1'b0, cyc, rst);
        verify(1, 24'h000249, LEN_B, 1'b1, cyc);
        check("hello_key_ok", if_b.key_ok, 1);
        for (int k = 0; k < LEN_B; k++) check("hello_text", d_at(1, k), hw_str[k]);

        // random keys and ciphertext, no check
        for (int it = 0; it < 3; it++) begin
            key = 24'($urandom);
            for (int k = 0; k < LEN_A; k++) set_rom(0, k, 8'($urandom));
            run(0, key, 0, 0, 1'b0, cyc, rst);
            verify(0, key, LEN_A, 1'b0, cyc);
        end

        // random keys with lowercase text, sometimes corrupted
        for (int it = 0; it < 4; it++) begin
            key = 24'($urandom);
            for (int k = 0; k < LEN_B; k++) begin
                r = int'($urandom_range(0, 26));
                plain[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            end
            if ((it % 2) == 1) plain[$urandom_range(0, LEN_B - 1)] = 8'($urandom);
            rc4_ref(key, LEN_B, 1'b0, 1, nw, ok);
            for (int k = 0; k < LEN_B; k++) set_rom(1, k, 8'(m_ks[k]) ^ plain[k]);
            run(1, key, 0, 0, 1'b0, cyc, rst);
            verify(1, key, LEN_B, 1'b1, cyc);
        end

        check("no_dual_write", both_cnt, 0);
        check("no_write_in_reset", rstwr_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
